// File: rtl/regfile_mp_sb_pkg.sv
// Shared pipeline defines for the multi-port register file.
// Default widths and port counts used by ID/WB.
package regfile_mp_sb_pkg;

    localparam int RF_DW    = 32;
    localparam int RF_AW    = 5;
    localparam int RF_NRD   = 2;
    localparam int RF_NWR   = 2;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_mp_sb_sb.sv
// Busy-bit scoreboard: issue sets, writeback clears, issue wins.
// Provides the per-read-port busy lookup before any output register.
module regfile_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int AW     = RF_AW,
    parameter int NRD    = RF_NRD,
    parameter int NWR    = RF_NWR,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    localparam int DEPTH = 2**AW;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] clr;
    logic [DEPTH-1:0] set;
    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        clr = '0;
        set = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                clr[wr_addr[i*AW +: AW]] = 1'b1;
            end
        end
        if (iss_en) begin
            set[iss_addr] = 1'b1;
        end
        busy_nxt = (busy & ~clr) | set;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // A same-cycle writeback forwards its data, so the reader is not stalled.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_busy[k] = busy[rd_addr[k*AW +: AW]]
                       && !((BYPASS != 0) && clr[rd_addr[k*AW +: AW]]);
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and busy scoreboard.
// Register 0 reads as zero and is never busy.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int DW      = RF_DW,
    parameter int AW      = RF_AW,
    parameter int NRD     = RF_NRD,
    parameter int NWR     = RF_NWR,
    parameter int SYNC_RD = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [DW-1:0]  mem [DEPTH];
    logic [NRD-1:0] busy_c;

    // Later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && wr_addr[i*AW +: AW] != ZERO) begin
                    mem[wr_addr[i*AW +: AW]] <= wr_data[i*DW +: DW];
                end
            end
        end
    end

    assign dbg_data = (dbg_addr == ZERO) ? '0 : mem[dbg_addr];

    regfile_sb #(
        .AW     (AW),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_sb (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (busy_c)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rv;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            rv = mem[ra];
            if (BYPASS != 0) begin
                for (int i = 0; i < NWR; i++) begin
                    if (wr_en[i] && wr_addr[i*AW +: AW] == ra) begin
                        rv = wr_data[i*DW +: DW];
                    end
                end
            end
            if (ra == ZERO) begin
                rv = '0;
            end
        end

        if (SYNC_RD != 0) begin : g_sync
            logic [DW-1:0] rd_q;
            logic          busy_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    rd_q   <= '0;
                    busy_q <= 1'b0;
                end else begin
                    rd_q   <= rv;
                    busy_q <= busy_c[k];
                end
            end

            assign rd_data[k*DW +: DW] = rd_q;
            assign rd_busy[k]          = busy_q;
        end else begin : g_comb
            assign rd_data[k*DW +: DW] = rv;
            assign rd_busy[k]          = busy_c[k];
        end
    end

endmodule
